// File: rtl/display_pkg.sv
// Shared constants for the keypad-lock display: blank/dash codes, the
// active-low glyph table (bit 0 = a, bit 6 = g) and the digit-count width.
package display_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'h3F;

   localparam logic [6:0] GLYPH [10] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
      7'h12, 7'h02, 7'h78, 7'h00, 7'h10
   };

   // Width needed to hold a digit count of 0..digits.
   function automatic int cw(input int digits);
      return $clog2(digits + 1);
   endfunction

endpackage

// File: rtl/bcd_to_7seg.sv
// Combinational nibble to active-low 7-segment decoder; 10..15 show a dash.
module bcd_to_7seg
   import display_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg_n
);

   always_comb begin
      seg_n = SEG_DASH;
      if (bcd < 4'd10) seg_n = GLYPH[bcd];
   end

endmodule

// File: rtl/bcd_display_scanner.sv
// Time-multiplexed 7-segment scanner with per-frame shadow snapshot and alarm
// blink. Define DISPLAY_MASK_EN to add mask_in, which turns lit digits into dashes.
module bcd_display_scanner
   import display_pkg::*;
#(
   parameter  int DIGITS       = 4,
   parameter  int SCAN_DIV     = 1024,
   parameter  int BLINK_FRAMES = 32,
   localparam int CW           = cw(DIGITS)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic [4*DIGITS-1:0] digits_in,
   input  logic [CW-1:0]       count_in,
   input  logic                alarm,
   input  logic                unlocked,
`ifdef DISPLAY_MASK_EN
   input  logic                mask_in,
`endif
   output logic [DIGITS-1:0]   an_n,
   output logic [6:0]          seg_n,
   output logic                dp_n,
   output logic                frame_start
);

   localparam int PW = $clog2(SCAN_DIV);
   localparam int IW = $clog2(DIGITS);
   localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [PW-1:0]       pre;
   logic [IW-1:0]       idx;
   logic [BW-1:0]       bf;
   logic                phase;
   logic                pre_wrap, idx_wrap;

   logic [4*DIGITS-1:0] sh_digits;
   logic [CW-1:0]       sh_count;
   logic                sh_alarm, sh_unlocked, sh_mask;
   logic [CW-1:0]       count_sat;
   logic                mask_d;

   logic                s1_vld;
   logic [IW-1:0]       s1_idx;
   logic                lit;
   logic [3:0]          nibble;
   logic [6:0]          dec_seg;

`ifdef DISPLAY_MASK_EN
   assign mask_d = mask_in;
`else
   assign mask_d = 1'b0;
`endif

   assign pre_wrap    = (pre == PW'(SCAN_DIV - 1));
   assign idx_wrap    = (idx == IW'(DIGITS - 1));
   assign frame_start = en && !rst && (pre == '0) && (idx == '0);
   assign count_sat   = (count_in > CW'(DIGITS)) ? CW'(DIGITS) : count_in;

   always_ff @(posedge clk) begin
      if (rst) begin
         pre <= '0;
         idx <= '0;
      end else if (en) begin
         pre <= pre_wrap ? '0 : pre + 1'b1;
         if (pre_wrap) idx <= idx_wrap ? '0 : idx + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sh_digits   <= '0;
         sh_count    <= '0;
         sh_alarm    <= 1'b0;
         sh_unlocked <= 1'b0;
         sh_mask     <= 1'b0;
      end else if (frame_start) begin
         sh_digits   <= digits_in;
         sh_count    <= count_sat;
         sh_alarm    <= alarm;
         sh_unlocked <= unlocked;
         sh_mask     <= mask_d;
      end
   end

   // Held in the on phase whenever no alarm is shown, so a new alarm starts lit.
   always_ff @(posedge clk) begin
      if (rst || !sh_alarm) begin
         bf    <= '0;
         phase <= 1'b1;
      end else if (frame_start) begin
         if (bf == BW'(BLINK_FRAMES - 1)) begin
            bf    <= '0;
            phase <= ~phase;
         end else begin
            bf <= bf + 1'b1;
         end
      end
   end

   // One slot-select stage ahead of the output register gives the two-cycle
   // latency and lets slot 0 pick up the shadow loaded at frame start.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_vld <= 1'b0;
         s1_idx <= '0;
      end else begin
         s1_vld <= en;
         s1_idx <= idx;
      end
   end

   assign lit    = en && s1_vld && (CW'(s1_idx) < sh_count) && (!sh_alarm || phase);
   assign nibble = sh_mask ? 4'hF : sh_digits[{s1_idx, 2'b00} +: 4];

   bcd_to_7seg u_dec (
      .bcd   (nibble),
      .seg_n (dec_seg)
   );

   always_ff @(posedge clk) begin
      if (rst || !lit) begin
         an_n  <= '1;
         seg_n <= SEG_BLANK;
         dp_n  <= 1'b1;
      end else begin
         an_n  <= ~(DIGITS'(1) << s1_idx);
         seg_n <= dec_seg;
         dp_n  <= ~sh_unlocked;
      end
   end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Bench for bcd_display_scanner: frame-level model checked every cycle plus
// hand-computed checkpoints (DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2).
module tb_bcd_display_scanner;

   localparam int D = 4;
   localparam int S = 4;
   localparam int B = 2;
`ifdef DISPLAY_MASK_EN
   localparam bit MASK_ON = 1'b1;
`else
   localparam bit MASK_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic [15:0] digits_in = '0;
   logic [2:0]  count_in = '0;
   logic        alarm = 1'b0, unlocked = 1'b0, mask_in = 1'b0;
   logic [3:0]  an_n;
   logic [6:0]  seg_n;
   logic        dp_n, frame_start;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = -1000;

   always #5 clk = ~clk;

   bcd_display_scanner #(.DIGITS(D), .SCAN_DIV(S), .BLINK_FRAMES(B)) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .digits_in   (digits_in),
      .count_in    (count_in),
      .alarm       (alarm),
      .unlocked    (unlocked),
`ifdef DISPLAY_MASK_EN
      .mask_in     (mask_in),
`endif
      .an_n        (an_n),
      .seg_n       (seg_n),
      .dp_n        (dp_n),
      .frame_start (frame_start)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
      end
   endtask

   function automatic logic [6:0] glyph(input int v);
      case (v)
         0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
         4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
         8: return 7'h00;  9: return 7'h10;
         default: return 7'h3F;
      endcase
   endfunction

   // Model: scan position follows from the count of enabled cycles; blink
   // phase from how many frames the alarm has been shown.
   int          ticks = 0, k = 0, idx1 = 0, sc = 0;
   bit          en1 = 0, sa = 0, su = 0, sm = 0, cmp_on = 0;
   logic [15:0] sd = '0;
   logic [3:0]  x_an = 4'hF;
   logic [6:0]  x_seg = 7'h7F;
   logic        x_dp = 1'b1;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial forever begin
      bit on;
      int d;
      @(posedge clk);
      if (rst) begin
         ticks = 0; k = 0; idx1 = 0; en1 = 0;
         sd = '0; sc = 0; sa = 0; su = 0; sm = 0;
         x_an = 4'hF; x_seg = 7'h7F; x_dp = 1'b1;
         cmp_on = 1;
      end else begin
         on = !sa || ((k / B) % 2 == 0);
         if (en && en1 && idx1 < sc && on) begin
            d     = int'(sd[idx1*4 +: 4]);
            x_an  = ~(4'(1) << idx1);
            x_seg = sm ? 7'h3F : glyph(d);
            x_dp  = !su;
         end else begin
            x_an = 4'hF; x_seg = 7'h7F; x_dp = 1'b1;
         end
         en1  = en;
         idx1 = (ticks / S) % D;
         if (en && (ticks % (D * S) == 0)) begin
            k  = (alarm && sa) ? k + 1 : 0;
            sd = digits_in;
            sc = (int'(count_in) > D) ? D : int'(count_in);
            sa = alarm;
            su = unlocked;
            sm = MASK_ON && mask_in;
         end
         if (en) ticks++;
      end
   end

   initial forever begin
      @(negedge clk);
      if (cmp_on) begin
         chk("an_n", an_n, x_an);
         chk("seg_n", seg_n, x_seg);
         chk("dp_n", dp_n, x_dp);
         chk("frame_start", frame_start, en && !rst && (ticks % (D * S) == 0));
      end
   end

   task automatic go_neg(input int c);
      while (cyc < c) begin @(posedge clk); #1; end
      @(negedge clk);
   endtask

   task automatic go_drv(input int c);
      while (cyc < c) begin @(posedge clk); #1; end
      #2;
   endtask

   task automatic lit(input int c, input logic [3:0] a, input logic [6:0] s, input logic dp);
      go_neg(c);
      chk("lit_an", an_n, a);
      chk("lit_seg", seg_n, s);
      chk("lit_dp", dp_n, dp);
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      #3;
      rst = 0; en = 1; digits_in = 16'h4321; count_in = 3'd4; cyc = 0;
      go_neg(0);
      chk("lit_fs0", frame_start, 1'b1);
      lit(2, 4'hE, 7'h79, 1'b1);
      lit(6, 4'hD, 7'h24, 1'b1);
      lit(10, 4'hB, 7'h30, 1'b1);
      lit(14, 4'h7, 7'h19, 1'b1);
      go_drv(15); count_in = 3'd2;
      go_drv(20); count_in = 3'd7;
      lit(23, 4'hD, 7'h24, 1'b1);
      lit(26, 4'hF, 7'h7F, 1'b1);
      go_drv(40); digits_in = 16'h9999;
      lit(44, 4'hB, 7'h30, 1'b1);
      lit(46, 4'h7, 7'h19, 1'b1);
      lit(50, 4'hE, 7'h10, 1'b1);
      go_drv(52); digits_in = 16'hC987;
      go_drv(60); unlocked = 1;
      lit(63, 4'h7, 7'h10, 1'b1);
      lit(66, 4'hE, 7'h78, 1'b0);
      go_drv(70); alarm = 1;
      lit(78, 4'h7, 7'h3F, 1'b0);
      lit(82, 4'hE, 7'h78, 1'b0);
      lit(98, 4'hE, 7'h78, 1'b0);
      lit(114, 4'hF, 7'h7F, 1'b1);
      lit(130, 4'hF, 7'h7F, 1'b1);
      lit(146, 4'hE, 7'h78, 1'b0);
      go_drv(150); alarm = 0;
      lit(162, 4'hE, 7'h78, 1'b0);
      lit(178, 4'hE, 7'h78, 1'b0);
      go_drv(185); en = 0;
      lit(190, 4'hF, 7'h7F, 1'b1);
      chk("lit_fs_pause", frame_start, 1'b0);
      go_drv(195); en = 1;
      lit(196, 4'hF, 7'h7F, 1'b1);
      lit(197, 4'hB, 7'h10, 1'b0);
      lit(200, 4'h7, 7'h3F, 1'b0);
      chk("lit_fs_201", frame_start, 1'b0);
      go_neg(202);
      chk("lit_fs_resume", frame_start, 1'b1);
      go_drv(210); rst = 1;
      lit(211, 4'hF, 7'h7F, 1'b1);
      chk("lit_fs_rst", frame_start, 1'b0);
      go_drv(212); rst = 0;
      go_neg(212);
      chk("lit_fs_after_rst", frame_start, 1'b1);
      lit(214, 4'hE, 7'h78, 1'b0);
`ifdef DISPLAY_MASK_EN
      go_drv(230); mask_in = 1; count_in = 3'd3;
      lit(246, 4'hE, 7'h3F, 1'b0);
      lit(254, 4'hB, 7'h3F, 1'b0);
      lit(258, 4'hF, 7'h7F, 1'b1);
`endif
      go_neg(264);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
